// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, requester ids and constants for the regfile writeback arbiter
package rf_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } reqId_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-write bit vector with read-after-write hazard lookup
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              setEn,
    input  logic [ADDR_W-1:0] setReg,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrReg,
    input  logic [ADDR_W-1:0] chkRegA,
    input  logic [ADDR_W-1:0] chkRegB,
    output logic              hazard,
    output logic [NREGS-1:0]  pending
);

    logic [NREGS-1:0] setMask;
    logic [NREGS-1:0] clrMask;
    logic [NREGS-1:0] pendingNext;

    // A reservation landing on the same edge as a retiring write is a newer
    // producer, so the set is applied after the clear.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (setEn) setMask[setReg] = 1'b1;
        if (clrEn) clrMask[clrReg] = 1'b1;
        pendingNext           = (pending & ~clrMask) | setMask;
        pendingNext[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    assign hazard = pending[chkRegA] | pending[chkRegB];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the regfile write port between ALU and LSU
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] chk_reg_a,
    input  logic [ADDR_W-1:0] chk_reg_b,
    output logic              hazard,
    output logic [NREGS-1:0]  pending,
    output logic [CNT_W-1:0]  conflict_cnt
);

    reqId_e            lastGrant;
    logic              grant0;
    logic              grant1;
    logic              anyGrant;
    logic              bothValid;
    logic [ADDR_W-1:0] winReg;
    logic [DATA_W-1:0] winData;
    logic [CNT_W-1:0]  conflictCnt;

    always_comb begin
        bothValid = req0_valid & req1_valid;
        grant0    = req0_valid & (!req1_valid || lastGrant == REQ_LSU);
        grant1    = req1_valid & (!req0_valid || lastGrant == REQ_ALU);
        anyGrant  = grant0 | grant1;
        winReg    = grant1 ? req1_reg  : req0_reg;
        winData   = grant1 ? req1_data : req0_data;
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign conflict_cnt = conflictCnt;

    // Writes to register 0 still win arbitration and advance the round-robin
    // pointer; they just never raise the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lastGrant   <= REQ_LSU;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            conflictCnt <= '0;
        end else begin
            rf_we <= anyGrant && (winReg != ZERO_REG);
            if (anyGrant) begin
                lastGrant <= grant1 ? REQ_LSU : REQ_ALU;
                rf_waddr  <= winReg;
                rf_wdata  <= winData;
            end
            if (bothValid && (conflictCnt != '1)) begin
                conflictCnt <= conflictCnt + CNT_W'(1);
            end
        end
    end

    rf_scoreboard uScoreboard (
        .clk     (clk),
        .reset   (reset),
        .setEn   (rsv_valid),
        .setReg  (rsv_reg),
        .clrEn   (anyGrant),
        .clrReg  (winReg),
        .chkRegA (chk_reg_a),
        .chkRegB (chk_reg_b),
        .hazard  (hazard),
        .pending (pending)
    );

endmodule
